dmux8way_bank16: RTL and testbench

//  Write-side counterpart of the 8-way 16-bit read mux: a demultiplexing register bank that steers a

---
 rtl/dmux8way_bank16.sv | 99 +++++++++
 tb/tb_dmux8way_bank16.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmux8way_bank16.sv
// ============================================================================
// Module  : dmux8way_bank16
// Brief   : Burst-addressed write bank; one-hot demux strobes feed 8 x 16-bit
//           registers. Optional READBACK_EN adds a combinational read port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dmux8way_bank16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AW-1:0]          base,
  input  logic [3:0]             count,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          ptr,
  output logic [DEPTH-1:0]       load,
  output logic [DEPTH*WIDTH-1:0] regs
`ifdef READBACK_EN
  ,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  logic [1:0]       state;
  logic [3:0]       remaining;
  logic             xfer;
  logic [WIDTH-1:0] mem [DEPTH];

  // Handshake outputs are decoded from state alone so in_valid never loops back.
  assign in_ready = (state == BURST);
  assign busy     = (state == BURST);
  assign done     = (state == FIN);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count != 4'd0) begin
              ptr       <= base;
              remaining <= count;
              state     <= BURST;
            end else begin
              state <= FIN;
            end
          end
        end
        BURST: begin
          if (xfer) begin
            ptr       <= ptr + AW'(1);
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1) state <= FIN;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      assign load[i] = xfer && (ptr == AW'(i));

      always_ff @(posedge clock or posedge reset) begin
        if (reset)        mem[i] <= '0;
        else if (load[i]) mem[i] <= in_data;
      end

      assign regs[i*WIDTH +: WIDTH] = mem[i];
    end
  endgenerate

`ifdef READBACK_EN
  assign rd_data = mem[rd_addr];
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmux8way_bank16.sv
// ============================================================================
// Module  : tb_dmux8way_bank16
// Brief   : Directed self-checking bench for dmux8way_bank16.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmux8way_bank16;

  logic         clock;
  logic         reset;
  logic         start;
  logic [2:0]   base;
  logic [3:0]   count;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         in_ready;
  logic         busy;
  logic         done;
  logic [2:0]   ptr;
  logic [7:0]   load;
  logic [127:0] regs;
`ifdef READBACK_EN
  logic [2:0]   rd_addr;
  logic [15:0]  rd_data;
`endif

  int passed = 0;
  int total  = 0;

  dmux8way_bank16 dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .count    (count),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .ptr      (ptr),
    .load     (load),
    .regs     (regs)
`ifdef READBACK_EN
    ,
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] reg_at(input int i);
    return regs[i*16 +: 16];
  endfunction

  task automatic test_reset();
    total++; if (regs !== 128'h0) $display("FAIL reset_regs got %h exp 0", regs); else passed++;
    total++; if ({in_ready, busy, done} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {in_ready, busy, done}); else passed++;
    total++; if (ptr !== 3'd0 || load !== 8'h00) $display("FAIL reset_ptr_load got %0d/%h exp 0/00", ptr, load); else passed++;
    reset = 1'b0;
    step();
    // reset after 2 of 4 words
    start = 1'b1; base = 3'd0; count = 4'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234; step();
    in_data = 16'h5678; step();
    in_valid = 1'b0;
    total++; if (reg_at(1) !== 16'h5678) $display("FAIL pre_abort_write got %h exp 5678", reg_at(1)); else passed++;
    reset = 1'b1;
    #1;
    total++; if (regs !== 128'h0) $display("FAIL abort_regs got %h exp 0", regs); else passed++;
    total++; if (busy !== 1'b0 || ptr !== 3'd0 || done !== 1'b0) $display("FAIL abort_state got busy=%b ptr=%0d done=%b exp 0/0/0", busy, ptr, done); else passed++;
    reset = 1'b0;
    step();
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_no_done got done=%b busy=%b exp 0/0", done, busy); else passed++;
  endtask

  task automatic test_full_burst();
    start = 1'b1; base = 3'd0; count = 4'd8;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL burst_enter got busy=%b rdy=%b exp 1/1", busy, in_ready); else passed++;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i + 1);
      #1;
      total++; if (load !== 8'(1 << i)) $display("FAIL load_walk[%0d] got %h exp %h", i, load, 8'(1 << i)); else passed++;
      step();
    end
    in_valid = 1'b0;
    total++; if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL full_done got done=%b busy=%b rdy=%b exp 1/0/0", done, busy, in_ready); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (reg_at(i) !== 16'(i + 1)) $display("FAIL full_reg[%0d] got %h exp %h", i, reg_at(i), 16'(i + 1)); else passed++;
    end
    step();
    total++; if (done !== 1'b0 || ptr !== 3'd0) $display("FAIL full_after got done=%b ptr=%0d exp 0/0", done, ptr); else passed++;
  endtask

  task automatic test_wrap();
    logic [15:0] vals [4];
    vals[0] = 16'hAAAA; vals[1] = 16'hBBBB; vals[2] = 16'hCCCC; vals[3] = 16'hDDDD;
    start = 1'b1; base = 3'd6; count = 4'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      step();
    end
    in_valid = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL wrap_done got %b exp 1", done); else passed++;
    total++; if (reg_at(6) !== 16'hAAAA || reg_at(7) !== 16'hBBBB) $display("FAIL wrap_hi got %h %h exp aaaa bbbb", reg_at(6), reg_at(7)); else passed++;
    total++; if (reg_at(0) !== 16'hCCCC || reg_at(1) !== 16'hDDDD) $display("FAIL wrap_lo got %h %h exp cccc dddd", reg_at(0), reg_at(1)); else passed++;
    total++; if (reg_at(2) !== 16'h0003 || reg_at(5) !== 16'h0006) $display("FAIL wrap_untouched got %h %h exp 0003 0006", reg_at(2), reg_at(5)); else passed++;
    total++; if (ptr !== 3'd2) $display("FAIL wrap_ptr got %0d exp 2", ptr); else passed++;
    step();
  endtask

  task automatic test_valid_gaps();
    start = 1'b1; base = 3'd2; count = 4'd2;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111; step();
    total++; if (ptr !== 3'd3) $display("FAIL gap_ptr1 got %0d exp 3", ptr); else passed++;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b0; in_data = 16'hDEAD;
      #1;
      total++; if (load !== 8'h00) $display("FAIL gap_load[%0d] got %h exp 00", k, load); else passed++;
      step();
      total++; if (ptr !== 3'd3 || busy !== 1'b1) $display("FAIL gap_hold[%0d] got ptr=%0d busy=%b exp 3/1", k, ptr, busy); else passed++;
    end
    in_valid = 1'b1; in_data = 16'h2222; step();
    in_valid = 1'b0;
    total++; if (done !== 1'b1 || ptr !== 3'd4) $display("FAIL gap_done got done=%b ptr=%0d exp 1/4", done, ptr); else passed++;
    total++; if (reg_at(2) !== 16'h1111 || reg_at(3) !== 16'h2222 || reg_at(4) !== 16'h0005)
      $display("FAIL gap_regs got %h %h %h exp 1111 2222 0005", reg_at(2), reg_at(3), reg_at(4)); else passed++;
    step();
  endtask

  task automatic test_zero_and_ignore();
    start = 1'b1; base = 3'd5; count = 4'd0;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'hFFFF;
    #1;
    total++; if (done !== 1'b1 || load !== 8'h00 || busy !== 1'b0) $display("FAIL zero_done got done=%b load=%h busy=%b exp 1/00/0", done, load, busy); else passed++;
    step();
    in_valid = 1'b0;
    total++; if (done !== 1'b0 || regs[79:64] !== 16'h0005) $display("FAIL zero_after got done=%b r4=%h exp 0/0005", done, regs[79:64]); else passed++;
    start = 1'b1; base = 3'd4; count = 4'd1;
    step();
    base = 3'd0; count = 4'd5;
    in_valid = 1'b1; in_data = 16'h7777;
    step();
    start = 1'b0; in_valid = 1'b0;
    total++; if (done !== 1'b1 || ptr !== 3'd5 || reg_at(4) !== 16'h7777)
      $display("FAIL ignore_start got done=%b ptr=%0d r4=%h exp 1/5/7777", done, ptr, reg_at(4)); else passed++;
    step();
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ignore_idle got busy=%b done=%b exp 0/0", busy, done); else passed++;
  endtask

`ifdef READBACK_EN
  task automatic test_readback();
    rd_addr = 3'd3;
    start = 1'b1; base = 3'd3; count = 4'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    total++; if (rd_data !== 16'hBEEF) $display("FAIL readback got %h exp beef", rd_data); else passed++;
    rd_addr = 3'd7;
    #1;
    total++; if (rd_data !== 16'h0008) $display("FAIL readback7 got %h exp 0008", rd_data); else passed++;
    step();
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; base = '0; count = '0; in_valid = 1'b0; in_data = '0;
`ifdef READBACK_EN
    rd_addr = '0;
`endif
    #12;
    test_reset();
    test_full_burst();
    test_wrap();
    test_valid_gaps();
    test_zero_and_ignore();
`ifdef READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
